// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory-stage responder.
// Holds FSM encoding, bus width defaults and opcode constants.
package cpu_pkg;

  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [3:0] OP_PUSHPOP = 4'd7;
  localparam logic [3:0] OP_CALLRET = 4'd11;
  localparam logic [3:0] OP_LDDSTD  = 4'd12;
  localparam logic [3:0] OP_LDI     = 4'd13;
  localparam logic [3:0] OP_STI     = 4'd14;

endpackage

// File: rtl/data_mem_responder_if.sv
// Memory-stage to data-memory request/ready bundle.
// master: mem_req, Wm, addr, wdata out; rdata, mem_ready, stall, busy in.
interface data_mem_responder_if #(
  parameter int ADDR_W = cpu_pkg::CPU_ADDR_W,
  parameter int DATA_W = cpu_pkg::CPU_DATA_W
);

  logic              mem_req;
  logic              Wm;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_ready;
  logic              stall;
  logic              busy;

  modport master (
    output mem_req, Wm, addr, wdata,
    input  rdata, mem_ready, stall, busy
  );

  modport slave (
    input  mem_req, Wm, addr, wdata,
    output rdata, mem_ready, stall, busy
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM, registered write and read.
// Ports: clk, rst_n, we_i, re_i, addr_i, wdata_i; rdata_o holds last read.
module dmem_ram #(
  parameter int ADDR_W = cpu_pkg::CPU_ADDR_W,
  parameter int DATA_W = cpu_pkg::CPU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Output register only moves on a read, so it holds across writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one access, waits, pulses mem_ready.
// Ports: clk, rst_n, bus (slave: mem_req/Wm/addr/wdata in; rdata/mem_ready/stall/busy out).
module data_mem_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = CPU_ADDR_W,
  parameter int DATA_W      = CPU_DATA_W,
  parameter int WAIT_STATES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);

  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic              req_wm_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;

  logic              accept;
  logic              cur_wm;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;

  assign accept = (state_q == IDLE) && bus.mem_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_wm_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_wm_q    <= bus.Wm;
        req_addr_q  <= bus.addr;
        req_wdata_q <= bus.wdata;
      end
    end
  end

  // With zero wait states RESP is entered on the accept edge itself,
  // before the latches hold the request, so IDLE uses the live bus.
  assign cur_wm   = (state_q == IDLE) ? bus.Wm : req_wm_q;
  assign ram_addr = (state_q == IDLE) ? bus.addr : req_addr_q;

  assign ram_re = rst_n && (state_d == RESP) && !cur_wm;
  assign ram_we = rst_n && (state_q == RESP) && req_wm_q;

  dmem_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (ram_addr),
    .wdata_i(req_wdata_q),
    .rdata_o(bus.rdata)
  );

  assign bus.mem_ready = (state_q == RESP);
  assign bus.busy      = (state_q != IDLE);
  assign bus.stall     = accept || (state_q == WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
// Two instances: wait states 2 (sel 0) and 0 (sel 1).
module tb_data_mem_responder;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  data_mem_responder_if b2 ();
  data_mem_responder_if b0 ();

  data_mem_responder #(.WAIT_STATES(2)) u2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b2.slave)
  );

  data_mem_responder #(.WAIT_STATES(0)) u0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b0.slave)
  );

  function automatic logic wm_of(input logic [3:0] op, input bit pop);
    if (op == OP_LDI) return 1'b0;
    if (op == OP_STI) return 1'b1;
    return !pop;
  endfunction

  task automatic drv(input bit sel, input logic req, input logic wm,
                     input logic [7:0] a, input logic [7:0] d);
    if (sel) begin
      b0.mem_req = req; b0.Wm = wm; b0.addr = a; b0.wdata = d;
    end else begin
      b2.mem_req = req; b2.Wm = wm; b2.addr = a; b2.wdata = d;
    end
  endtask

  // lat: negedges from accept cycle (0) to mem_ready, -1 on timeout.
  task automatic do_acc(input bit sel, input logic wm,
                        input logic [7:0] a, input logic [7:0] d,
                        output int lat, output int stl,
                        output logic [7:0] rd, output int rcyc);
    @(posedge clk); #1;
    drv(sel, 1'b1, wm, a, d);
    lat = -1; stl = 0; rd = '0; rcyc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sel ? b0.stall : b2.stall) stl++;
      if (sel ? b0.mem_ready : b2.mem_ready) begin
        lat = c;
        rd = sel ? b0.rdata : b2.rdata;
        rcyc = cyc;
        break;
      end
      if (c == 0) begin
        @(posedge clk); #1;
        drv(sel, 1'b0, wm, a, d);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv(0, 0, 0, 8'h00, 8'h00);
    drv(1, 0, 0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ((s ? b0.rdata : b2.rdata) !== 8'h00) begin
        errs++;
        $display("FAIL reset_rdata dut%0d got=%h exp=00", s,
                 s ? b0.rdata : b2.rdata);
      end
      checks++;
      if ((s ? b0.mem_ready : b2.mem_ready) !== 1'b0) begin
        errs++;
        $display("FAIL reset_ready dut%0d got=%b exp=0", s,
                 s ? b0.mem_ready : b2.mem_ready);
      end
      checks++;
      if ((s ? b0.stall : b2.stall) !== 1'b0) begin
        errs++;
        $display("FAIL reset_stall dut%0d got=%b exp=0", s,
                 s ? b0.stall : b2.stall);
      end
      checks++;
      if ((s ? b0.busy : b2.busy) !== 1'b0) begin
        errs++;
        $display("FAIL reset_busy dut%0d got=%b exp=0", s,
                 s ? b0.busy : b2.busy);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    int lat, stl, rc;
    logic [7:0] rd;
    do_acc(0, wm_of(OP_LDDSTD, 0), 8'h10, 8'hA5, lat, stl, rd, rc);
    checks++;
    if (lat !== 3) begin
      errs++; $display("FAIL st_latency got=%0d exp=3", lat);
    end
    checks++;
    if (stl !== 3) begin
      errs++; $display("FAIL st_stall_cycles got=%0d exp=3", stl);
    end
    checks++;
    if (rd !== 8'h00) begin
      errs++; $display("FAIL st_rdata_held got=%h exp=00", rd);
    end
    do_acc(0, wm_of(OP_LDDSTD, 1), 8'h10, 8'h00, lat, stl, rd, rc);
    checks++;
    if (lat !== 3) begin
      errs++; $display("FAIL ld_latency got=%0d exp=3", lat);
    end
    checks++;
    if (rd !== 8'hA5) begin
      errs++; $display("FAIL ld_rdata got=%h exp=a5", rd);
    end
  endtask

  task automatic test_ws0();
    int lat, stl, rc;
    logic [7:0] rd;
    do_acc(1, wm_of(OP_STI, 0), 8'hFF, 8'h3C, lat, stl, rd, rc);
    do_acc(1, wm_of(OP_STI, 0), 8'h00, 8'hC3, lat, stl, rd, rc);
    checks++;
    if (lat !== 1) begin
      errs++; $display("FAIL ws0_st_latency got=%0d exp=1", lat);
    end
    do_acc(1, wm_of(OP_LDI, 1), 8'hFF, 8'h00, lat, stl, rd, rc);
    checks++;
    if (lat !== 1) begin
      errs++; $display("FAIL ws0_ld_latency got=%0d exp=1", lat);
    end
    checks++;
    if (stl !== 1) begin
      errs++; $display("FAIL ws0_stall_cycles got=%0d exp=1", stl);
    end
    checks++;
    if (rd !== 8'h3C) begin
      errs++; $display("FAIL ws0_rdata_ff got=%h exp=3c", rd);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (b0.rdata !== 8'h3C || b0.mem_ready !== 1'b0) begin
      errs++;
      $display("FAIL ws0_hold rdata=%h ready=%b exp=3c/0",
               b0.rdata, b0.mem_ready);
    end
    do_acc(1, wm_of(OP_LDI, 1), 8'h00, 8'h00, lat, stl, rd, rc);
    checks++;
    if (rd !== 8'hC3) begin
      errs++; $display("FAIL ws0_rdata_00 got=%h exp=c3", rd);
    end
  endtask

  task automatic test_input_change();
    int lat, stl, rc;
    logic [7:0] rd;
    bit seen;
    do_acc(0, 1'b1, 8'h21, 8'h5A, lat, stl, rd, rc);
    @(posedge clk); #1;
    drv(0, 1'b1, 1'b1, 8'h20, 8'h11);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b1, 8'h21, 8'h99);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (b2.mem_ready) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (seen !== 1'b1) begin
      errs++; $display("FAIL chg_ready got=%b exp=1", seen);
    end
    do_acc(0, 1'b0, 8'h20, 8'h00, lat, stl, rd, rc);
    checks++;
    if (rd !== 8'h11) begin
      errs++; $display("FAIL chg_ram20 got=%h exp=11", rd);
    end
    do_acc(0, 1'b0, 8'h21, 8'h00, lat, stl, rd, rc);
    checks++;
    if (rd !== 8'h5A) begin
      errs++; $display("FAIL chg_ram21 got=%h exp=5a", rd);
    end
  endtask

  task automatic test_reset_mid();
    int lat, stl, rc;
    logic [7:0] rd;
    do_acc(0, 1'b1, 8'h30, 8'h00, lat, stl, rd, rc);
    @(posedge clk); #1;
    drv(0, 1'b1, 1'b1, 8'h30, 8'h77);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b1, 8'h30, 8'h77);
    @(negedge clk);
    checks++;
    if (b2.busy !== 1'b1 || b2.stall !== 1'b1) begin
      errs++;
      $display("FAIL rmid_wait busy=%b stall=%b exp=1/1",
               b2.busy, b2.stall);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (b2.busy !== 1'b0 || b2.mem_ready !== 1'b0) begin
      errs++;
      $display("FAIL rmid_idle busy=%b ready=%b exp=0/0",
               b2.busy, b2.mem_ready);
    end
    checks++;
    if (b2.stall !== 1'b0 || b2.rdata !== 8'h00) begin
      errs++;
      $display("FAIL rmid_out stall=%b rdata=%h exp=0/00",
               b2.stall, b2.rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_acc(0, 1'b0, 8'h30, 8'h00, lat, stl, rd, rc);
    checks++;
    if (lat !== 3 || rd !== 8'h00) begin
      errs++;
      $display("FAIL rmid_read lat=%0d rdata=%h exp=3/00", lat, rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat, stl, c1, c2;
    logic [7:0] rd;
    do_acc(0, 1'b0, 8'h10, 8'h00, lat, stl, rd, c1);
    do_acc(0, wm_of(OP_CALLRET, 0), 8'hFE, 8'h42, lat, stl, rd, c1);
    checks++;
    if (rd !== 8'hA5) begin
      errs++; $display("FAIL b2b_wr_rdata got=%h exp=a5", rd);
    end
    do_acc(0, wm_of(OP_PUSHPOP, 1), 8'hFE, 8'h00, lat, stl, rd, c2);
    checks++;
    if ((c2 - c1) !== 4) begin
      errs++; $display("FAIL b2b_spacing got=%0d exp=4", c2 - c1);
    end
    checks++;
    if (rd !== 8'h42) begin
      errs++; $display("FAIL b2b_rdata got=%h exp=42", rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_ws0();
    test_input_change();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
